// File: rtl/mpu_pkg.sv
// Shared constants, FSM state type and helpers for the MPU matrix loader.
package mpu_pkg;

    localparam int MPU_N        = 5;
    localparam int MPU_ELEM_W   = 8;
    localparam int MPU_MATRIX_W = MPU_N * MPU_N * MPU_ELEM_W;
    localparam int MPU_CNT_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Offset of element (r,c) measured from the MSB end of the packed matrix.
    function automatic int slot_offset(input logic [MPU_CNT_W-1:0] r,
                                       input logic [MPU_CNT_W-1:0] c);
        return MPU_ELEM_W * (int'(c) + MPU_N * int'(r));
    endfunction

    function automatic logic size_legal(input logic signed [7:0] s);
        return (s >= 8'sd1) && (s <= 8'(MPU_N));
    endfunction

endpackage

// File: rtl/mpu_rc_counter.sv
// Row-major row/column counter: wraps the column at size-1 and flags the
// final (size-1, size-1) position so the loader knows the stream is complete.
module mpu_rc_counter
    import mpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [MPU_CNT_W-1:0] size,
    output logic [MPU_CNT_W-1:0] row,
    output logic [MPU_CNT_W-1:0] col,
    output logic                 last
);

    logic [MPU_CNT_W-1:0] max_idx;
    logic                 col_wrap;

    assign max_idx  = size - MPU_CNT_W'(1);
    assign col_wrap = (col == max_idx);
    assign last     = col_wrap && (row == max_idx);

    // Returning to (0,0) after the last element keeps both counters below size.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row <= '0;
            col <= '0;
        end else if (enable) begin
            if (last) begin
                row <= '0;
                col <= '0;
            end else if (col_wrap) begin
                row <= row + MPU_CNT_W'(1);
                col <= '0;
            end else begin
                col <= col + MPU_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mpu_matrix_loader.sv
// Loads a size x size signed matrix from a row-major element stream into the
// packed operand vector of the determinant stage. Optional: MPU_LOADER_ZERO_FILL_EN.
module mpu_matrix_loader
    import mpu_pkg::*;
#(
    parameter int N      = MPU_N,
    parameter int ELEM_W = MPU_ELEM_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_size,
    output logic                  cmd_err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ELEM_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*N*ELEM_W-1:0] out_matrix,
    output logic [7:0]            out_size,
    output logic [1:0]            dbg_state
);

    localparam int MATRIX_W = N * N * ELEM_W;

    // Every channel: a transfer happens on a rising edge where valid and ready
    // are both high; ready depends only on FSM state, never on valid.
    state_t               state, state_nxt;
    logic [MATRIX_W-1:0]  buf_q;
    logic [7:0]           size_q;
    logic                 cmd_err_q;
    logic [MPU_CNT_W-1:0] row, col;
    logic                 last;
    logic                 cmd_hs, cmd_take, cmd_bad, in_take;
    logic [7:0]           wr_lsb;

    assign cmd_hs   = cmd_ready && cmd_valid;
    assign cmd_take = cmd_hs && size_legal(cmd_size);
    assign cmd_bad  = cmd_hs && !size_legal(cmd_size);
    assign in_take  = in_ready && in_valid;
    assign wr_lsb   = 8'(MATRIX_W - ELEM_W - slot_offset(row, col));

    mpu_rc_counter u_rc_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (cmd_take),
        .enable (in_take),
        .size   (size_q[MPU_CNT_W-1:0]),
        .row    (row),
        .col    (col),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cmd_take) state_nxt = LOAD;
            LOAD:    if (in_take && last) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:    cmd_ready = 1'b1;
            LOAD:    in_ready  = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // A command and an element can never land in the same cycle (IDLE vs LOAD).
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q     <= '0;
            size_q    <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= cmd_bad;
            if (cmd_take) begin
                size_q <= cmd_size;
`ifdef MPU_LOADER_ZERO_FILL_EN
                buf_q  <= '0;
`endif
            end
            if (in_take) begin
                buf_q[wr_lsb +: ELEM_W] <= in_data;
            end
        end
    end

    assign cmd_err    = cmd_err_q;
    assign out_matrix = buf_q;
    assign out_size   = size_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Self-checking bench for mpu_matrix_loader: table of commands, hand-written
// corner sequences and randomized loads against a 5x5 array model.
module tb_mpu_matrix_loader;
    import mpu_pkg::*;

    localparam int MW = MPU_MATRIX_W;
`ifdef MPU_LOADER_ZERO_FILL_EN
    localparam logic [7:0] STALE_BYTE = 8'h00;
`else
    localparam logic [7:0] STALE_BYTE = 8'h55;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_err;
    logic [7:0]    cmd_size;
    logic          in_valid, in_ready;
    logic [7:0]    in_data;
    logic          out_valid, out_ready;
    logic [MW-1:0] out_matrix;
    logic [7:0]    out_size;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    mpu_matrix_loader dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_size   (cmd_size),
        .cmd_err    (cmd_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_matrix (out_matrix),
        .out_size   (out_size),
        .dbg_state  (dbg_state)
    );

    int         n_vec  = 0;
    int         n_err  = 0;
    int         n_xfer = 0;
    logic [7:0] mem [5][5];
    logic [7:0] m_size;
    logic [7:0] elems [25];

    typedef struct {
        logic [7:0] size;
        logic       exp_err;
        int         hold;
    } vec_t;
    vec_t tbl [10];

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) n_xfer++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Row-major concatenation: element (0,0) lands in the top byte.
    function automatic logic [MW-1:0] model_vec();
        logic [MW-1:0] v;
        v = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                v = (v << 8) | {{(MW-8){1'b0}}, mem[r][c]};
        return v;
    endfunction

    function automatic logic [7:0] slot(input logic [MW-1:0] v, input int r, input int c);
        logic [MW-1:0] t;
        t = v << (8 * (5 * r + c));
        return t[MW-1 -: 8];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                mem[r][c] = 8'h00;
        m_size = 8'd0;
    endtask

    task automatic send_cmd(input logic [7:0] s, input logic exp_err);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_size  = s;
        step();
        cmd_valid = 1'b0;
        check("cmd_err", cmd_err, exp_err);
        check("in_ready_after_cmd", in_ready, !exp_err);
        if (!exp_err) begin
            m_size = s;
`ifdef MPU_LOADER_ZERO_FILL_EN
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    mem[r][c] = 8'h00;
`endif
        end else begin
            check("cmd_ready_stays_idle", cmd_ready, 1);
            step();
            check("cmd_err_one_pulse", cmd_err, 0);
            check("in_ready_stays_low", in_ready, 0);
        end
    endtask

    task automatic stream(input int n, input int max_gap);
        int sz;
        int g;
        sz = int'(m_size);
        for (int k = 0; k < n; k++) begin
            g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
            for (int j = 0; j < g; j++) begin
                in_valid = 1'b0;
                step();
            end
            check("in_ready_load", in_ready, 1);
            check("no_early_out_valid", out_valid, 0);
            in_valid = 1'b1;
            in_data  = elems[k];
            step();
            in_valid = 1'b0;
            mem[k / sz][k % sz] = elems[k];
        end
    endtask

    task automatic take_output(input int hold, input logic poke_cmd);
        logic [MW-1:0] ev;
        int            x0;
        ev = model_vec();
        x0 = n_xfer;
        check("out_valid", out_valid, 1);
        check("in_ready_hold", in_ready, 0);
        for (int j = 0; j < hold; j++) begin
            if (poke_cmd) begin
                cmd_valid = 1'b1;
                cmd_size  = 8'd3;
            end
            step();
            check("hold_valid", out_valid, 1);
            check("hold_matrix", out_matrix, ev);
            check("hold_size", out_size, m_size);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        check("out_matrix", out_matrix, ev);
        check("out_size", out_size, m_size);
        check("xfer_none_while_held", n_xfer - x0, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("xfer_count", n_xfer - x0, 1);
        check("out_valid_dropped", out_valid, 0);
        check("cmd_ready_after_xfer", cmd_ready, 1);
        check("in_ready_after_xfer", in_ready, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_cmd_err"}, cmd_err, 0);
        check({tag, "_out_matrix"}, out_matrix, '0);
        check({tag, "_out_size"}, out_size, 0);
        check({tag, "_state"}, dbg_state, IDLE);
    endtask

    initial begin
        int sz;
        int det;
        tbl[0] = '{8'd0,   1'b1, 0};
        tbl[1] = '{8'd6,   1'b1, 0};
        tbl[2] = '{8'hFF,  1'b1, 0};
        tbl[3] = '{8'h80,  1'b1, 0};
        tbl[4] = '{8'd7,   1'b1, 0};
        tbl[5] = '{8'd1,   1'b0, 0};
        tbl[6] = '{8'd2,   1'b0, 3};
        tbl[7] = '{8'd3,   1'b0, 1};
        tbl[8] = '{8'd4,   1'b0, 0};
        tbl[9] = '{8'd5,   1'b0, 2};

        rst = 1'b1; cmd_valid = 1'b0; cmd_size = 8'd0;
        in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        model_reset();
        step();
        step();
        check_reset_outputs("in_reset");
        rst = 1'b0;
        step();
        check_reset_outputs("after_reset");

        // Elements offered while IDLE must not be consumed.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int j = 0; j < 3; j++) begin
            step();
            check("idle_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;

        // Size 2, stream 1..4, no gaps: out_valid right after the 4th beat.
        send_cmd(8'd2, 1'b0);
        for (int k = 0; k < 4; k++) elems[k] = 8'(k + 1);
        stream(4, 0);
        check("s2_slot00", slot(out_matrix, 0, 0), 8'd1);
        check("s2_slot01", slot(out_matrix, 0, 1), 8'd2);
        check("s2_slot10", slot(out_matrix, 1, 0), 8'd3);
        check("s2_slot11", slot(out_matrix, 1, 1), 8'd4);
        det = int'($signed(slot(out_matrix, 0, 0))) * int'($signed(slot(out_matrix, 1, 1)))
            - int'($signed(slot(out_matrix, 0, 1))) * int'($signed(slot(out_matrix, 1, 0)));
        check("s2_det", det, -2);
        take_output(0, 1'b0);

        // Size 5, 1..25 with random gaps, held 10 cycles with a command poked.
        send_cmd(8'd5, 1'b0);
        for (int k = 0; k < 25; k++) elems[k] = 8'(k + 1);
        stream(25, 3);
        check("s5_slot43", slot(out_matrix, 4, 3), 8'd24);
        take_output(10, 1'b1);
        check("s5_poke_ignored", in_ready, 0);

        // Size 1, element -7: out_valid two cycles after the command.
        send_cmd(8'd1, 1'b0);
        elems[0] = 8'hF9;
        stream(1, 0);
        check("s1_slot00", slot(out_matrix, 0, 0), 8'hF9);
        take_output(0, 1'b0);

        // Size 3 after a size-5 load of 0x55: stale region depends on zero fill.
        send_cmd(8'd5, 1'b0);
        for (int k = 0; k < 25; k++) elems[k] = 8'h55;
        stream(25, 0);
        take_output(1, 1'b0);
        send_cmd(8'd3, 1'b0);
        for (int k = 0; k < 9; k++) elems[k] = 8'($urandom);
        stream(9, 1);
        check("s3_unused_44", slot(out_matrix, 4, 4), STALE_BYTE);
        check("s3_unused_03", slot(out_matrix, 0, 3), STALE_BYTE);
        take_output(2, 1'b0);

        // Command table: illegal sizes pulse cmd_err, legal ones load random data.
        for (int i = 0; i < 10; i++) begin
            send_cmd(tbl[i].size, tbl[i].exp_err);
            if (!tbl[i].exp_err) begin
                sz = int'(tbl[i].size);
                for (int k = 0; k < sz * sz; k++) elems[k] = 8'($urandom);
                stream(sz * sz, 2);
                take_output(tbl[i].hold, 1'b0);
            end
        end

        // Reset after 3 of 9 elements discards the partial matrix.
        send_cmd(8'd3, 1'b0);
        for (int k = 0; k < 9; k++) elems[k] = 8'($urandom_range(255, 1));
        stream(3, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        check_reset_outputs("mid_load_reset");
        in_valid = 1'b1;
        in_data  = 8'h11;
        for (int j = 0; j < 3; j++) begin
            step();
            check("post_reset_no_out_valid", out_valid, 0);
            check("post_reset_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        send_cmd(8'd2, 1'b0);
        elems[0] = 8'd9; elems[1] = 8'd8; elems[2] = 8'd7; elems[3] = 8'd6;
        stream(4, 0);
        check("post_reset_unused_22", slot(out_matrix, 2, 2), 8'h00);
        take_output(1, 1'b0);

        // Randomized loads.
        for (int i = 0; i < 15; i++) begin
            sz = $urandom_range(5, 1);
            send_cmd(8'(sz), 1'b0);
            for (int k = 0; k < sz * sz; k++) elems[k] = 8'($urandom);
            stream(sz * sz, 2);
            take_output($urandom_range(4, 0), 1'($urandom_range(1, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mpu_matrix_loader.md
# mpu_matrix_loader

- Sits directly upstream of the MPU determinant stage.
- Accepts a load command carrying a matrix size of 1..5 and then a row-major stream of signed 8-bit elements.
- Assembles the elements into the packed 5x5 operand vector. Element (r,c) occupies the 8-bit slice starting at bit offset 8*(c+5*r); bit index 0 is the MSB of the 200-bit vector.
- Presents the matrix and size with a valid/ready handshake and holds them stable until the consumer takes them.

## Interface
Parameters:
- N, 5, maximum matrix dimension
- ELEM_W, 8, element width in bits

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  load command present
- cmd_ready  output  1  command accepted this cycle when both high
- cmd_size  input  8  signed matrix size; legal range 1..5
- cmd_err  output  1  one-cycle pulse: command with illegal size was rejected
- in_valid  input  1  element present
- in_ready  output  1  element accepted this cycle when both high
- in_data  input  8  signed element, row-major order
- out_valid  output  1  assembled matrix available
- out_ready  input  1  consumer takes matrix when both high
- out_matrix  output  200  packed matrix, same layout as the determinant stage input
- out_size  output  8  signed size of the matrix being presented

## Operation
- FSM states and their outputs:
  - IDLE: cmd_ready=1.
  - LOAD: in_ready=1.
  - HOLD: out_valid=1.
- IDLE, command handshake with cmd_size in 1..5:
  - Latch the size.
  - Clear the row and column counters to 0.
  - Move to LOAD.
- IDLE, command handshake with cmd_size ≤0 or >5:
  - Pulse cmd_err on the next cycle.
  - Stay in IDLE; size and buffer are unchanged.
- LOAD, each element handshake:
  - Write in_data to slot (row,col).
  - If col==size-1, set col=0 and row=row+1; otherwise col=col+1.
  - The element with row==size-1 and col==size-1 is the last one; after it, go to HOLD.
- HOLD:
  - out_matrix and out_size are stable.
  - On out_ready, go to IDLE.
  - cmd_valid is ignored until IDLE (cmd_ready=0).
- Slots outside the top-left size×size region are never written by the stream.
- in_valid outside LOAD is ignored; no element is consumed.
- Counters are 3 bits and never exceed size-1.

## Timing
- Reset values: state IDLE; row, col and size = 0; buffer all zero.
- Output values in reset: cmd_ready=1 (state is IDLE), in_ready=0, out_valid=0, cmd_err=0, out_matrix=0, out_size=0.
- A command accepted in cycle t gives in_ready=1 in cycle t+1.
- The last element accepted in cycle t gives out_valid=1 in cycle t+1.
- Throughput in LOAD: one element per cycle.
- Minimum command-to-out_valid time: size*size+1 cycles.
- The out handshake in cycle t gives cmd_ready=1 in cycle t+1.
- There is no overlap of commands: each command starts after the previous matrix has been consumed.
- Backpressure:
  - out_ready held low keeps HOLD indefinitely; outputs do not change.
  - in_valid gaps stall the counters.
- rst asserted in any state returns all state and outputs to their reset values on the next edge.
  - A partially loaded matrix is discarded.
  - No out_valid is produced for it.
- Handshake signals are level-based; ready is never combinationally dependent on valid.

## Configuration
- MPU_LOADER_ZERO_FILL_EN
  - Defined: a legal command handshake clears the whole 200-bit buffer in that same cycle. Slots outside size×size therefore read 0 in HOLD.
  - Undefined: the buffer is not cleared on a command. Unused slots keep prior contents. The determinant stage reads only the top-left size×size region, so results are identical; this saves 200 clear muxes.

## Structure
- Shared package mpu_pkg:
  - constants MPU_N=5, MPU_ELEM_W=8, MPU_MATRIX_W=200
  - function for the slot offset 8*(c+5*r)
  - state enum {IDLE, LOAD, HOLD}
  - size legality check (1..MPU_N)
- One sub-module: mpu_rc_counter.
  - Function: row/column counter with wrap at size-1 and a last flag.
  - Ports: enable, clear and size inputs; row, col and last outputs.
- The top level holds the FSM, the buffer register and the output regs.

## Test plan
- Size 2, stream 1,2,3,4:
  - out_valid one cycle after the 4th beat.
  - Slots (0,0)=1, (0,1)=2, (1,0)=3, (1,1)=4; out_size=2.
  - Downstream determinant = -2.
- Size 5, stream 1..25 with random in_valid gaps and out_ready held low 10 cycles:
  - Slot (r,c)=5r+c+1.
  - Outputs stable throughout HOLD.
  - Exactly one transfer.
- cmd_size=0 and then cmd_size=6:
  - cmd_err pulses once for each.
  - State stays IDLE; in_ready stays 0.
- Size 1, stream -7:
  - out_valid two cycles after the command; slot (0,0)=-7.
- Size 3 after a prior size-5 load of all 0x55:
  - With the macro: unused slots = 0.
  - Without the macro: unused slots = 0x55.
- rst asserted after 3 of 9 size-3 elements:
  - Next cycle: IDLE, cmd_ready=1, buffer zero.
  - A new size-2 load completes correctly.
